// File: rtl/fetch_stage.sv
// Instruction-fetch front end: holds the fetch PC, issues word reads to a
// variable-latency instruction memory over a req/ack handshake, buffers the
// returned words in a 2-entry FIFO and presents the head entry to the F/D latch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 12
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fd_valid,
  output logic [31:0]       fd_insn,
  output logic [31:0]       fd_pc_plus_1,
  output logic              fd_enable
);

  // StWait: a request is in flight and its data is wanted.
  // StDrop: a request is in flight but a redirect made its data stale.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        count_q, count_d;

  // Queue storage: slot 0 is always the head, slot 1 the tail.
  logic [31:0]       head_insn_q, head_insn_d;
  logic [31:0]       head_pcp1_q, head_pcp1_d;
  logic [31:0]       tail_insn_q, tail_insn_d;
  logic [31:0]       tail_pcp1_q, tail_pcp1_d;

  logic              pop;
  logic              push;
  logic [31:0]       pc_inc;
  logic [1:0]        count_post;

  // Queue control: pop, push and the occupancy after this edge.
  always_comb begin
    pop    = (count_q != 2'd0) && !stall && !redirect;
    // In StWait the issued address always equals pc_q, so pc_q is the
    // address of the word returning with this ack.
    push   = (state_q == StWait) && imem_ack && !redirect;
    pc_inc = pc_q + 32'd1;
    if (redirect) begin
      count_post = 2'd0;
    end else begin
      count_post = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  // Fetch state machine: next PC, request and address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (count_post < 2'd2) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = pc_d[ADDR_W-1:0];
        end
      end
      StWait: begin
        if (imem_ack) begin
          if (redirect) begin
            // Returned word is stale; reissue straight to the new target.
            pc_d   = redirect_pc;
            addr_d = redirect_pc[ADDR_W-1:0];
          end else begin
            pc_d = pc_inc;
            if (count_post < 2'd2) begin
              addr_d = pc_inc[ADDR_W-1:0];
            end else begin
              state_d = StIdle;
              req_d   = 1'b0;
            end
          end
        end else if (redirect) begin
          // Request must stay stable until its ack, so park in StDrop.
          pc_d    = redirect_pc;
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = StWait;
          addr_d  = pc_d[ADDR_W-1:0];
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // Queue data movement; contents are don't-care once count drops to zero.
  always_comb begin
    head_insn_d = head_insn_q;
    head_pcp1_d = head_pcp1_q;
    tail_insn_d = tail_insn_q;
    tail_pcp1_d = tail_pcp1_q;
    count_d     = count_post;
    if (!redirect) begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_insn_d = imem_rdata;
            head_pcp1_d = pc_inc;
          end else begin
            tail_insn_d = imem_rdata;
            tail_pcp1_d = pc_inc;
          end
        end
        2'b01: begin
          head_insn_d = tail_insn_q;
          head_pcp1_d = tail_pcp1_q;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_insn_d = imem_rdata;
            head_pcp1_d = pc_inc;
          end else begin
            head_insn_d = tail_insn_q;
            head_pcp1_d = tail_pcp1_q;
            tail_insn_d = imem_rdata;
            tail_pcp1_d = pc_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC[ADDR_W-1:0];
      count_q     <= 2'd0;
      head_insn_q <= 32'd0;
      head_pcp1_q <= 32'd0;
      tail_insn_q <= 32'd0;
      tail_pcp1_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      head_insn_q <= head_insn_d;
      head_pcp1_q <= head_pcp1_d;
      tail_insn_q <= tail_insn_d;
      tail_pcp1_q <= tail_pcp1_d;
    end
  end

  // Outputs: registered except fd_enable; an empty queue presents a nop.
  always_comb begin
    imem_req     = req_q;
    imem_addr    = addr_q;
    fd_valid     = (count_q != 2'd0);
    fd_insn      = fd_valid ? head_insn_q : 32'd0;
    fd_pc_plus_1 = fd_valid ? head_pcp1_q : 32'd0;
    fd_enable    = !stall;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the five-stage pipeline. Holds the fetch PC, issues word reads to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue. Presents the head entry to the F/D pipeline latch together with that latch's enable. Handles downstream stalls and branch/jump redirects, including a redirect that arrives while a memory read is outstanding.

## Interface
- RESET_PC, 0, PC loaded at reset (word address).
- ADDR_W, 12, instruction-memory address width.

- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  read request; registered
- imem_addr  out  ADDR_W  word address, equal to pc[ADDR_W-1:0]; registered
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- stall  in  1  F/D latch must hold this cycle
- redirect  in  1  taken branch/jump; flush fetch
- redirect_pc  in  32  new fetch PC, sampled when redirect=1
- fd_valid  out  1  head queue entry present
- fd_insn  out  32  head instruction; 0 (nop) when fd_valid=0
- fd_pc_plus_1  out  32  head entry PC + 1; 0 when fd_valid=0
- fd_enable  out  1  F/D latch enable, equal to !stall

## Operation
- Reset is active-low and synchronous: while reset=0 at a rising edge, state=IDLE, pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC[ADDR_W-1:0].
- With count=0 after reset: fd_valid=0, fd_insn=0, fd_pc_plus_1=0, fd_enable=!stall.
- Reset overrides everything, including an outstanding request. The memory must tolerate req being dropped by reset.
- Queue: 2 entries {insn, pc}, FIFO, count 0..2.
  - Pop at the edge when count!=0, stall=0 and redirect=0.
  - Push at the edge of an accepted ack (state WAIT, redirect=0).
  - Push and pop in the same cycle leave count unchanged.
- PC is 32-bit and wraps modulo 2^32. pc+1 is computed modulo 2^32. The pc register advances by 1 on every accepted ack.
- Handshake:
  - Once imem_req rises, it and imem_addr stay stable until the cycle in which imem_ack=1, inclusive.
  - ack may arrive in the first req cycle.
  - ack while req=0 is illegal and is ignored.
- At most one request is outstanding. A new request is issued only when count<2, so the queue never overflows.
- State machine:
  - IDLE (req=0):
    - redirect loads pc.
    - If count<2 at the edge (after any pop), go to WAIT with req=1, addr=pc (post-redirect).
  - WAIT (req=1):
    - ack & !redirect: push, pc++. If count after push/pop is <2, stay WAIT with the new addr (back-to-back issue). Otherwise go to IDLE with req=0.
    - ack & redirect: drop data, clear queue, pc=redirect_pc, stay WAIT with addr=redirect_pc.
    - !ack & redirect: clear queue, pc=redirect_pc, go to DROP; req and addr are held.
  - DROP (req=1, old addr held):
    - On ack, discard data; go to WAIT with addr=pc.
    - Another redirect updates pc and stays in DROP. Redirect together with ack: take the new pc, go to WAIT.
- Redirect always clears the queue at its edge, and pop is suppressed. Redirect has priority over stall.
- Discarding the instruction in F/D on a redirect is downstream's responsibility.

## Timing
- Data returned with ack at edge t is visible on fd_* in cycle t+1.
- Zero-wait memory (ack in the first req cycle) with no stalls sustains 1 instruction per cycle after a 1-cycle startup.
- Redirect at edge t: pc=redirect_pc from t+1.
  - If no request is outstanding, or ack came the same cycle: req to redirect_pc is in cycle t+1.
  - If a request is outstanding without ack: the redirect_pc request goes out the cycle after the stale ack.
- Outputs depend only on registers, except fd_enable (combinational from stall).
- Stall holds fd_* stable. Fetch continues until count=2.

## Test plan
- Reset held low for 3 cycles, then released; memory acks every req immediately -> fd_insn follows the words at addresses 0,1,2…, one per cycle from the 2nd cycle after reset; fd_pc_plus_1 = 1,2,3…
- Ack latency of 3 cycles -> req and addr held stable 3 cycles per read; one instruction every 3 cycles; no duplicates or skips.
- stall=1 for 5 cycles while streaming -> count saturates at 2, req drops, and fd_insn holds the same word. After release, the two buffered words appear in order, then fetch resumes at the correct PC.
- redirect to 0x40 while a request to 0x05 is outstanding, ack 2 cycles later -> the 0x05 word never appears on fd_*. The next req has addr=0x40 and the next fd_pc_plus_1=0x41.
- redirect in the same cycle as ack, and a second redirect while in DROP -> data dropped; fetch resumes at the last redirect_pc; queue empty (fd_valid=0) after the redirect edge.
- RESET_PC=0xFFFFFFFF -> first fd_pc_plus_1 = 0; next request addr = 0. Reset asserted mid-WAIT -> next cycle req=0 and fd_valid=0.
